forward_ctrl: RTL
=================

// Module: forward_ctrl
// PURPOSE
//   Forwarding/hazard controller for the 5-stage RISC-V pipeline: the select-generating end of the
//   ForwardA/ForwardB operand muxes in EX. Tracks destination-register metadata through ID/EX,
//   EX/MEM and MEM/WB with its own shadow pipeline registers, and drives 2-bit mux selects,
//   the load-use stall and saturating hazard counters. Sits beside the ID/EX pipeline register.
// PARAMETERS
//   REG_AW   5    register-index width
//   CNT_W    16   width of each performance counter
// PORTS
//   clk_i          in   1       pipeline clock, rising edge
//   rst_n_i        in   1       asynchronous, active-low reset
//   ID_rs1_i       in   REG_AW  rs1 of instruction in ID
//   ID_rs2_i       in   REG_AW  rs2 of instruction in ID
//   ID_rs1_used_i  in   1       ID instruction reads rs1
//   ID_rs2_used_i  in   1       ID instruction reads rs2
//   ID_rd_i        in   REG_AW  rd of instruction in ID
//   ID_RegWrite_i  in   1       ID instruction writes rd
//   ID_MemRead_i   in   1       ID instruction is a load
//   flush_i        in   1       branch taken: ID instruction becomes a bubble
//   ForwardA_o     out  2       EX rs1 select: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result
//   ForwardB_o     out  2       EX rs2 select, same encoding
//   stall_o        out  1       load-use hazard: hold PC and IF/ID, bubble into ID/EX
//   fwd_cnt_o      out  CNT_W   cycles with ForwardA_o or ForwardB_o nonzero
//   stall_cnt_o    out  CNT_W   cycles with stall_o high
// BEHAVIOUR
//   - Shadow regs: ID/EX {rs1,rs2,rs1_used,rs2_used,rd,RegWrite,MemRead}; EX/MEM {rd,RegWrite};
//     MEM/WB {rd,RegWrite}. All advance every rising edge (no global freeze).
//   - Reset (rst_n_i low, async): all shadow regs and counters 0; hence ForwardA_o=ForwardB_o=00,
//     stall_o=0 immediately, held until first edge after deassertion. Reset mid-stream drops all
//     in-flight hazards; no forwarding resumes from pre-reset state.
//   - ID/EX load: if stall_o or flush_i, load bubble (RegWrite=0, MemRead=0, used bits=0, rd=0);
//     else capture ID_* inputs. EX/MEM <= ID/EX {rd,RegWrite}; MEM/WB <= EX/MEM.
//   - ForwardA_o (combinational from shadow regs only, no ID inputs), for rs = IDEX.rs1, used=IDEX.rs1_used:
//       10 if used && EXMEM.RegWrite && EXMEM.rd!=0 && EXMEM.rd==rs
//       else 01 if used && MEMWB.RegWrite && MEMWB.rd!=0 && MEMWB.rd==rs
//       else 00. EX/MEM wins over MEM/WB (newer value). 11 never driven.
//     ForwardB_o identical with rs2/rs2_used.
//   - stall_o (combinational): IDEX.MemRead && IDEX.rd!=0 &&
//     ((ID_rs1_used_i && ID_rs1_i==IDEX.rd) || (ID_rs2_used_i && ID_rs2_i==IDEX.rd)).
//     Exactly one stall cycle per load-use pair; next cycle the load is in EX/MEM and
//     ForwardA/B must NOT select EX/MEM for load data—load result reaches EX via MEM/WB (01)
//     one cycle later; stall_o therefore re-asserts? No: after one bubble the load is in MEM,
//     dependent in ID/EX sees it two stages ahead at WB time => select 01. One bubble suffices.
//   - stall_o and flush_i together: flush wins semantically (bubble either way); stall_o still
//     reported and counted.
//   - x0: rd==0 never forwards nor stalls, regardless of RegWrite.
//   - Counters: increment by 1 at clock edge when condition true; saturate at all-ones (no wrap).
//   - Latency: selects valid same cycle instruction occupies EX; stall valid same cycle as ID.
// TESTING
//   1 add x5 in ID, next cycle sub uses x5 as rs1 -> in EX cycle ForwardA_o=10, ForwardB_o=00.
//   2 producer x7, one independent instr, consumer rs2=x7 -> ForwardB_o=01; if both EX/MEM and
//     MEM/WB write x7 -> ForwardB_o=10 (priority).
//   3 lw x3 in ID/EX, ID add rs1=x3 -> stall_o=1 one cycle, ID/EX bubble, then add in EX with
//     ForwardA_o=01; stall_cnt_o=1.
//   4 producer rd=x0 RegWrite=1, consumer rs1=x0 -> ForwardA_o=00; lw x0 -> stall_o=0.
//   5 flush_i=1 on producer in ID -> no forwarding from it later; rs1_used=0 matching rd -> 00.
//   6 rst_n_i low mid-hazard -> outputs 0 asynchronously; counters force to 0xFFFF then +1 -> hold 0xFFFF.

Source files
------------

// File: rtl/forward_ctrl.sv
// -----------------------------------------------------------------------------
// forward_ctrl
//   Forwarding and hazard controller for a 5-stage RISC-V pipeline. It drives
//   the selects of the ForwardA/ForwardB operand muxes in EX and the load-use
//   stall. It keeps its own shadow copies of the destination-register metadata
//   in ID/EX, EX/MEM and MEM/WB. Two saturating counters track how often
//   forwarding and stalling occur.
//
// Ports
//   clk_i          pipeline clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   ID_rs1_i/ID_rs2_i, ID_rs1_used_i/ID_rs2_used_i
//                  source registers of the ID instruction, and whether each is read
//   ID_rd_i, ID_RegWrite_i, ID_MemRead_i
//                  destination register of the ID instruction, its write enable,
//                  and whether it is a load
//   flush_i        taken branch: the ID instruction enters ID/EX as a bubble
//   ForwardA_o/B_o EX operand selects:
//                    00 = register file, 01 = MEM/WB data, 10 = EX/MEM ALU result
//   stall_o        load-use hazard: hold PC and IF/ID, insert a bubble into ID/EX
//   fwd_cnt_o      number of cycles with either select nonzero (saturating)
//   stall_cnt_o    number of cycles with stall_o high (saturating)
// -----------------------------------------------------------------------------
module forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic              ID_rs1_used_i,
  input  logic              ID_rs2_used_i,
  input  logic [REG_AW-1:0] ID_rd_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemRead_i,
  input  logic              flush_i,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  fwd_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } idex_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wr_t;

  idex_t            idex_q,      idex_d;
  wr_t              exmem_q,     exmem_d;
  wr_t              memwb_q,     memwb_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  fwd_sel_e fwd_a, fwd_b;
  logic     stall;

  // Priority is EX/MEM first, then MEM/WB. EX/MEM holds the newer value of the
  // register. A write to x0 is never forwarded.
  function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] rs,
                                          input logic              used,
                                          input wr_t               exmem,
                                          input wr_t               memwb);
    if (used && exmem.reg_write && (exmem.rd != '0) && (exmem.rd == rs))
      return FWD_EXMEM;
    else if (used && memwb.reg_write && (memwb.rd != '0) && (memwb.rd == rs))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default value first, so no latch
    // is inferred on any path.
    idex_d      = idex_q;
    exmem_d     = exmem_q;
    memwb_d     = memwb_q;
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;

    // The selects depend only on the shadow registers, so the EX muxes see no
    // combinational path from the ID inputs.
    fwd_a = fwd_select(idex_q.rs1, idex_q.rs1_used, exmem_q, memwb_q);
    fwd_b = fwd_select(idex_q.rs2, idex_q.rs2_used, exmem_q, memwb_q);

    // Load-use check: the load sitting in ID/EX has no data until MEM. After
    // one bubble, the dependent instruction picks the data up from MEM/WB.
    stall = idex_q.mem_read && (idex_q.rd != '0) &&
            ((ID_rs1_used_i && (ID_rs1_i == idex_q.rd)) ||
             (ID_rs2_used_i && (ID_rs2_i == idex_q.rd)));

    if (stall || flush_i) begin
      idex_d = '0;
    end else begin
      idex_d.rs1       = ID_rs1_i;
      idex_d.rs2       = ID_rs2_i;
      idex_d.rs1_used  = ID_rs1_used_i;
      idex_d.rs2_used  = ID_rs2_used_i;
      idex_d.rd        = ID_rd_i;
      idex_d.reg_write = ID_RegWrite_i;
      idex_d.mem_read  = ID_MemRead_i;
    end

    exmem_d.rd        = idex_q.rd;
    exmem_d.reg_write = idex_q.reg_write;
    memwb_d           = exmem_q;

    // The counters saturate at all-ones instead of wrapping.
    if (((fwd_a != FWD_RF) || (fwd_b != FWD_RF)) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: state is written with non-blocking assignments, so every flop samples
  // its _d value from before this edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ForwardA_o  = fwd_a;
  assign ForwardB_o  = fwd_b;
  assign stall_o     = stall;
  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
